// File: rtl/assoc_mem_topk.sv
// assoc_mem_topk
// Associative-memory search engine. A start latches the query and the search
// CSRs, then class hypervectors are accepted over a valid/ready stream. Each
// accepted class is scored by Hamming distance against the latched query
// (stage 1) and merged into a sorted top-NumTop list (stage 2). A one-cycle
// done pulse marks the list as final; results hold until the next start.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   query_hv_i            query HV, latched on an accepted start
//   am_start_i            start request (honoured only when idle)
//   am_busy_o             high while scanning and draining
//   am_done_o             one-cycle pulse when results are final
//   class_hv_i            class HV stream data
//   class_hv_valid_i      class HV stream valid
//   class_hv_ready_o      class HV stream ready
//   csr_am_num_class_i    number of classes to scan (latched at start)
//   csr_am_thresh_i       rejection threshold (latched at start)
//   csr_am_thresh_en_i    threshold enable (latched at start)
//   csr_top_idx_o         class index per slot, slot 0 = best
//   csr_top_dist_o        distance per slot
//   csr_top_valid_o       slot occupied flags
//   csr_hit_o             slot 0 occupied
module assoc_mem_topk #(
  parameter int HVDimension = 512,
  parameter int DataWidth   = 8,
  parameter int DistWidth   = $clog2(HVDimension + 1),
  parameter int NumTop      = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [HVDimension-1:0]        query_hv_i,
  input  logic                          am_start_i,
  output logic                          am_busy_o,
  output logic                          am_done_o,
  input  logic [HVDimension-1:0]        class_hv_i,
  input  logic                          class_hv_valid_i,
  output logic                          class_hv_ready_o,
  input  logic [DataWidth-1:0]          csr_am_num_class_i,
  input  logic [DistWidth-1:0]          csr_am_thresh_i,
  input  logic                          csr_am_thresh_en_i,
  output logic [NumTop*DataWidth-1:0]   csr_top_idx_o,
  output logic [NumTop*DistWidth-1:0]   csr_top_dist_o,
  output logic [NumTop-1:0]             csr_top_valid_o,
  output logic                          csr_hit_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [HVDimension-1:0] query;
  logic [DataWidth-1:0]   num_class;
  logic [DataWidth-1:0]   count;
  logic [DistWidth-1:0]   thresh;
  logic                   thresh_en;

  logic                   start_acc;
  logic                   accept;

  logic                   vld_p1;
  logic [DistWidth-1:0]   dist_p1;
  logic [DataWidth-1:0]   idx_p1;

  logic [DataWidth-1:0]   slot_idx  [NumTop];
  logic [DistWidth-1:0]   slot_dist [NumTop];
  logic                   slot_vld  [NumTop];

  logic [DataWidth-1:0]   nxt_idx   [NumTop];
  logic [DistWidth-1:0]   nxt_dist  [NumTop];
  logic                   nxt_vld   [NumTop];
  logic                   take;

  function automatic logic [DistWidth-1:0] popcount(input logic [HVDimension-1:0] v);
    logic [DistWidth-1:0] acc;
    acc = '0;
    for (int i = 0; i < HVDimension; i++) begin
      acc = acc + DistWidth'(v[i]);
    end
    return acc;
  endfunction

  assign start_acc = am_start_i && (state == IDLE);
  assign accept    = class_hv_valid_i && class_hv_ready_o;

  // Control FSM; busy/done/ready are registered alongside the state so they
  // always reflect the state the engine is in during the current cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= IDLE;
      count            <= '0;
      am_busy_o        <= 1'b0;
      am_done_o        <= 1'b0;
      class_hv_ready_o <= 1'b0;
    end else begin
      am_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (am_start_i) begin
            count     <= '0;
            am_busy_o <= 1'b1;
            if (csr_am_num_class_i == '0) begin
              state            <= DRAIN;
              class_hv_ready_o <= 1'b0;
            end else begin
              state            <= SCAN;
              class_hv_ready_o <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (accept) begin
            count <= count + 1'b1;
            if (count == num_class - 1'b1) begin
              state            <= DRAIN;
              class_hv_ready_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          am_busy_o <= 1'b0;
          am_done_o <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state            <= IDLE;
          am_busy_o        <= 1'b0;
          class_hv_ready_o <= 1'b0;
        end
      endcase
    end
  end

  // Search context latch; the inputs are free to change once a search runs.
  always_ff @(posedge clk_i) begin
    if (start_acc) begin
      query     <= query_hv_i;
      num_class <= csr_am_num_class_i;
      thresh    <= csr_am_thresh_i;
      thresh_en <= csr_am_thresh_en_i;
    end
  end

  // ---- stage 1: Hamming distance of the accepted class ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      dist_p1 <= popcount(query ^ class_hv_i);
      idx_p1  <= count;
    end
  end

  // ---- stage 2: sorted insertion into the top-NumTop list ----
  // The valid slots form a sorted prefix, so the insertion point is the number
  // of valid slots whose distance is <= the candidate. Using <= places a new
  // candidate behind equal-distance entries, so earlier indices win ties.
  always_comb begin
    int pos;
    pos = 0;
    for (int k = 0; k < NumTop; k++) begin
      if (slot_vld[k] && (slot_dist[k] <= dist_p1)) begin
        pos = pos + 1;
      end
    end

    take = vld_p1 && !(thresh_en && (dist_p1 > thresh)) && (pos < NumTop);

    for (int k = 0; k < NumTop; k++) begin
      if (k < pos) begin
        nxt_idx[k]  = slot_idx[k];
        nxt_dist[k] = slot_dist[k];
        nxt_vld[k]  = slot_vld[k];
      end else if (k == pos) begin
        nxt_idx[k]  = idx_p1;
        nxt_dist[k] = dist_p1;
        nxt_vld[k]  = 1'b1;
      end else begin
        nxt_idx[k]  = slot_idx[(k > 0) ? k - 1 : 0];
        nxt_dist[k] = slot_dist[(k > 0) ? k - 1 : 0];
        nxt_vld[k]  = slot_vld[(k > 0) ? k - 1 : 0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || start_acc) begin
      for (int k = 0; k < NumTop; k++) begin
        slot_idx[k]  <= '0;
        slot_dist[k] <= '0;
        slot_vld[k]  <= 1'b0;
      end
    end else if (take) begin
      for (int k = 0; k < NumTop; k++) begin
        slot_idx[k]  <= nxt_idx[k];
        slot_dist[k] <= nxt_dist[k];
        slot_vld[k]  <= nxt_vld[k];
      end
    end
  end

  for (genvar g = 0; g < NumTop; g++) begin : g_out
    assign csr_top_idx_o[g*DataWidth +: DataWidth]  = slot_idx[g];
    assign csr_top_dist_o[g*DistWidth +: DistWidth] = slot_dist[g];
    assign csr_top_valid_o[g]                       = slot_vld[g];
  end

  assign csr_hit_o = slot_vld[0];

endmodule
